pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/hazard_shadow.sv | 110 +++++++++++
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard controller: cycle kinds,
// the shadow-pipeline entry, forwarding-select encoding and parameter checks.
package pipe_pkg;

  // Widest register address the shadow entry can carry.
  localparam int REG_AW_MAX = 8;

  // Forwarding select: 0 reads the regfile, k picks post-EX stage k.
  localparam int FWD_SEL_REGFILE = 0;

  // What the pipeline does on a given clock edge.
  typedef enum logic [1:0] {
    CYC_NORMAL = 2'd0,  // advance, ID enters EX
    CYC_STALL  = 2'd1,  // hold IF/ID, bubble into EX
    CYC_FLUSH  = 2'd2,  // kill wrong-path work younger than the branch
    CYC_HOLD   = 2'd3   // external freeze, nothing moves
  } cyc_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                  wr;  // writes a non-zero destination
    logic                  ld;  // destination value comes from memory
    logic [REG_AW_MAX-1:0] rd;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // Select code for a producer found at shadow index j: after the consumer
  // moves into EX, that producer sits in post-EX stage j+1.
  function automatic int fwd_sel_stage(input int j);
    return j + 1;
  endfunction

  function automatic bit params_ok(input int reg_aw, input int fwd_depth,
                                   input int ld_lat, input int br_stage,
                                   input int cnt_w);
    return (reg_aw >= 1) && (reg_aw <= REG_AW_MAX) &&
           (fwd_depth >= 2) && (fwd_depth <= 4) &&
           (ld_lat >= 1) && (ld_lat <= fwd_depth - 1) &&
           (br_stage >= 1) && (br_stage <= 2) &&
           (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/hazard_shadow.sv
// Shadow copy of the post-ID pipeline (index 0 = EX). Detects load-use
// hazards for the instruction in ID and registers its forwarding selects.
module hazard_shadow
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LD_LAT    = 1,
  parameter int BR_STAGE  = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  cyc_e              cyc,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  output logic              load_use,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b
);

  shadow_entry_t shadow_q [FWD_DEPTH];
  shadow_entry_t shadow_d [FWD_DEPTH];

  logic [SEL_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [SEL_W-1:0] fwd_a_nxt, fwd_b_nxt;
  logic [REG_AW_MAX-1:0] rs1_w, rs2_w;
  logic use1, use2;
  shadow_entry_t id_entry;

  // Compare the ID sources with every in-flight destination.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    rs1_w     = REG_AW_MAX'(id_rs1);
    rs2_w     = REG_AW_MAX'(id_rs2);
    use1      = id_valid & id_use_rs1 & (id_rs1 != '0);
    use2      = id_valid & id_use_rs2 & (id_rs2 != '0);
    load_use  = 1'b0;
    fwd_a_nxt = SEL_W'(FWD_SEL_REGFILE);
    fwd_b_nxt = SEL_W'(FWD_SEL_REGFILE);
    // Oldest first, so the nearest producer overwrites and wins.
    for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
      if (shadow_q[j].wr && (shadow_q[j].rd == rs1_w)) fwd_a_nxt = SEL_W'(fwd_sel_stage(j));
      if (shadow_q[j].wr && (shadow_q[j].rd == rs2_w)) fwd_b_nxt = SEL_W'(fwd_sel_stage(j));
    end
    // Load data is not ready while the load is within LD_LAT of EX.
    for (int j = 0; j < LD_LAT; j++) begin
      if (shadow_q[j].wr && shadow_q[j].ld &&
          ((use1 && (shadow_q[j].rd == rs1_w)) || (use2 && (shadow_q[j].rd == rs2_w))))
        load_use = 1'b1;
    end
  end

  // Next shadow contents and forwarding selects for each kind of cycle.
  always_comb begin
    id_entry.wr = id_valid & id_regwrite & (id_rd != '0);
    id_entry.ld = id_memread;
    id_entry.rd = REG_AW_MAX'(id_rd);
    shadow_d    = shadow_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    if (cyc != CYC_HOLD) begin
      for (int j = 1; j < FWD_DEPTH; j++) shadow_d[j] = shadow_q[j-1];
      shadow_d[0] = SHADOW_BUBBLE;
      fwd_a_d     = SEL_W'(FWD_SEL_REGFILE);
      fwd_b_d     = SEL_W'(FWD_SEL_REGFILE);
    end
    case (cyc)
      CYC_NORMAL: begin
        shadow_d[0] = id_entry;
        fwd_a_d     = fwd_a_nxt;
        fwd_b_d     = fwd_b_nxt;
      end
      CYC_FLUSH: begin
        // Entries that came from stages younger than the branch are wrong-path.
        for (int j = 1; j < FWD_DEPTH; j++)
          if (j < BR_STAGE) shadow_d[j] = SHADOW_BUBBLE;
      end
      default: ;
    endcase
  end

  // Shadow and select registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow is a handful of flops, not a RAM, so every entry is
      // reset; a stale wr bit after reset would raise false hazards.
      for (int j = 0; j < FWD_DEPTH; j++) shadow_q[j] <= SHADOW_BUBBLE;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would let the shift ripple through all stages at once.
      shadow_q <= shadow_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: picks the cycle kind (freeze > flush > stall),
// drives the stall/bubble/flush controls and keeps saturating event counts.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LD_LAT    = 1,
  parameter int BR_STAGE  = 2,
  parameter int CNT_W     = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               id_valid,
  input  logic [REG_AW-1:0]                  id_rs1,
  input  logic [REG_AW-1:0]                  id_rs2,
  input  logic                               id_use_rs1,
  input  logic                               id_use_rs2,
  input  logic [REG_AW-1:0]                  id_rd,
  input  logic                               id_regwrite,
  input  logic                               id_memread,
  input  logic                               branch_taken,
  input  logic                               ext_stall,
  output logic                               stall_if_id,
  output logic                               bubble_id_ex,
  output logic [BR_STAGE:0]                  flush,
  output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_sel_a,
  output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_sel_b,
  output logic [CNT_W-1:0]                   stall_cnt,
  output logic [CNT_W-1:0]                   flush_cnt
);

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  if (!params_ok(REG_AW, FWD_DEPTH, LD_LAT, BR_STAGE, CNT_W)) begin : g_bad_params
    $error("pipe_hazard_ctrl: illegal parameter combination");
  end

  logic             load_use;
  cyc_e             cyc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  hazard_shadow #(
    .REG_AW   (REG_AW),
    .FWD_DEPTH(FWD_DEPTH),
    .LD_LAT   (LD_LAT),
    .BR_STAGE (BR_STAGE),
    .SEL_W    (SEL_W)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .cyc        (cyc),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .load_use   (load_use),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b)
  );

  // Cycle priority: a freeze beats everything; a flush beats a stall because
  // the stalled instruction is on the wrong path anyway.
  always_comb begin
    cyc = CYC_NORMAL;
    if (ext_stall)         cyc = CYC_HOLD;
    else if (branch_taken) cyc = CYC_FLUSH;
    else if (load_use)     cyc = CYC_STALL;
  end

  // Controls are combinational and forced quiet while reset is held.
  assign stall_if_id  = ~reset & (cyc == CYC_STALL);
  assign bubble_id_ex = stall_if_id;
  assign flush        = {(BR_STAGE+1){~reset & (cyc == CYC_FLUSH)}};

  // Counter increments stop at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((cyc == CYC_STALL) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((cyc == CYC_FLUSH) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Event counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver predicts each cycle's
// outputs from an instruction-history model and queues them; a monitor pops
// and compares on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW    = 5;
  localparam int FWD_DEPTH = 2;
  localparam int LD_LAT    = 1;
  localparam int BR_STAGE  = 2;
  localparam int CNT_W     = 4;
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1);
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int FLUSH_ALL = (1 << (BR_STAGE + 1)) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic              id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic              id_regwrite = 1'b0, id_memread = 1'b0;
  logic              branch_taken = 1'b0, ext_stall = 1'b0;
  logic              stall_if_id, bubble_id_ex;
  logic [BR_STAGE:0] flush;
  logic [SEL_W-1:0]  fwd_sel_a, fwd_sel_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LD_LAT(LD_LAT),
    .BR_STAGE(BR_STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: hist[0] is the instruction that most recently left ID (now in EX),
  // hist[1] the one before it, and so on.
  typedef struct { bit wr; int rd; bit ld; } rec_t;
  typedef struct { bit stall; int flush; int fa; int fb; int sc; int fc; } want_t;

  rec_t  hist[$];
  want_t want_q[$];
  int    m_fa, m_fb, m_sc, m_fc;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // The most recent writer of r decides: forwarded if it is still within the
  // forwarding window once the consumer is in EX, otherwise the regfile.
  function automatic int fwd_of(input int r);
    for (int d = 0; d < hist.size(); d++)
      if (hist[d].wr && hist[d].rd == r) return (d < FWD_DEPTH) ? d + 1 : 0;
    return 0;
  endfunction

  function automatic bit load_use_of(input int v, input int rs1, input int u1,
                                     input int rs2, input int u2);
    bit used1, used2;
    used1 = (v != 0) && (u1 != 0) && (rs1 != 0);
    used2 = (v != 0) && (u2 != 0) && (rs2 != 0);
    for (int d = 0; d < LD_LAT && d < hist.size(); d++)
      if (hist[d].wr && hist[d].ld &&
          ((used1 && hist[d].rd == rs1) || (used2 && hist[d].rd == rs2))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endfunction

  function automatic void model_advance(input int v, input int rd, input int rw, input int mr,
                                        input int rs1, input int rs2, input int br,
                                        input int es, input bit lu);
    rec_t bub, nw;
    bub = '{wr: 1'b0, rd: 0, ld: 1'b0};
    if (es != 0) return;
    if (br != 0) begin
      // Everything younger than the branch (and the ID instruction) dies.
      for (int d = 0; d < BR_STAGE - 1 && d < hist.size(); d++) hist[d] = bub;
      hist.push_front(bub);
      m_fa = 0; m_fb = 0;
      if (m_fc < CNT_MAX) m_fc++;
    end else if (lu) begin
      hist.push_front(bub);
      m_fa = 0; m_fb = 0;
      if (m_sc < CNT_MAX) m_sc++;
    end else begin
      m_fa = fwd_of(rs1);
      m_fb = fwd_of(rs2);
      nw.wr = (v != 0) && (rw != 0) && (rd != 0);
      nw.rd = rd;
      nw.ld = (mr != 0);
      hist.push_front(nw);
    end
    while (hist.size() > 8) void'(hist.pop_back());
  endfunction

  task automatic drive_in(input int v, input int rd, input int rw, input int mr,
                          input int rs1, input int u1, input int rs2, input int u2,
                          input int br, input int es);
    id_valid     = (v != 0);
    id_rd        = REG_AW'(rd);
    id_regwrite  = (rw != 0);
    id_memread   = (mr != 0);
    id_rs1       = REG_AW'(rs1);
    id_use_rs1   = (u1 != 0);
    id_rs2       = REG_AW'(rs2);
    id_use_rs2   = (u2 != 0);
    branch_taken = (br != 0);
    ext_stall    = (es != 0);
  endtask

  // One pipeline cycle: drive ID, queue the prediction, advance the model.
  task automatic step(input int v, input int rd, input int rw, input int mr,
                      input int rs1, input int u1, input int rs2, input int u2,
                      input int br, input int es);
    want_t w;
    bit    lu;
    @(posedge clk); #1;
    drive_in(v, rd, rw, mr, rs1, u1, rs2, u2, br, es);
    lu      = load_use_of(v, rs1, u1, rs2, u2);
    w.stall = lu && (br == 0) && (es == 0);
    w.flush = ((br != 0) && (es == 0)) ? FLUSH_ALL : 0;
    w.fa    = m_fa;
    w.fb    = m_fb;
    w.sc    = m_sc;
    w.fc    = m_fc;
    want_q.push_back(w);
    model_advance(v, rd, rw, mr, rs1, rs2, br, es, lu);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    drive_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every queued prediction on the falling edge.
  initial begin
    want_t w;
    forever begin
      @(negedge clk);
      if (want_q.size() > 0) begin
        w = want_q.pop_front();
        check("stall_if_id",  32'(stall_if_id),  32'(w.stall));
        check("bubble_id_ex", 32'(bubble_id_ex), 32'(w.stall));
        check("flush",        32'(flush),        w.flush);
        check("fwd_sel_a",    32'(fwd_sel_a),    w.fa);
        check("fwd_sel_b",    32'(fwd_sel_b),    w.fb);
        check("stall_cnt",    32'(stall_cnt),    w.sc);
        check("flush_cnt",    32'(flush_cnt),    w.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", want_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #12;
    check("reset_stall", 32'(stall_if_id), 0);
    check("reset_flush", 32'(flush), 0);
    check("reset_fwd_a", 32'(fwd_sel_a), 0);
    check("reset_cnt",   32'(stall_cnt), 0);
    do_reset();

    // ALU to ALU forwarding: rd=5 then rs1=5.
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    @(negedge clk) check("alu_no_stall", 32'(stall_if_id), 0);
    nop();
    @(negedge clk) check("alu_fwd_a", 32'(fwd_sel_a), 1);

    // Load-use: load rd=6 then rs2=6 stalls exactly once, then MEM/WB forward.
    do_reset();
    step(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk) check("lu_stall", 32'(stall_if_id), 1);
    step(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk) check("lu_stall_once", 32'(stall_if_id), 0);
    nop();
    @(negedge clk) begin
      check("lu_fwd_b", 32'(fwd_sel_b), 2);
      check("lu_stall_cnt", 32'(stall_cnt), 1);
    end

    // Nearest stage wins; x0 never forwards or stalls.
    do_reset();
    step(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    nop();
    @(negedge clk) check("nearest_fwd_a", 32'(fwd_sel_a), 1);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk) check("x0_no_stall", 32'(stall_if_id), 0);
    nop();
    @(negedge clk) check("x0_fwd_a", 32'(fwd_sel_a), 0);

    // Branch taken in the same cycle as a load-use hazard.
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 6, 1, 1, 0);
    @(negedge clk) begin
      check("br_flush", 32'(flush), FLUSH_ALL);
      check("br_no_stall", 32'(stall_if_id), 0);
    end
    step(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk) check("br_killed_no_stall", 32'(stall_if_id), 0);
    nop();
    @(negedge clk) begin
      check("br_killed_no_fwd", 32'(fwd_sel_b), 0);
      check("br_flush_cnt", 32'(flush_cnt), 1);
    end

    // External freeze over a load-use hazard.
    do_reset();
    step(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 6, 1, 0, 1);
      @(negedge clk) begin
        check("frz_stall", 32'(stall_if_id), 0);
        check("frz_cnt", 32'(stall_cnt), 0);
      end
    end
    step(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk) check("frz_then_stall", 32'(stall_if_id), 1);
    step(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    nop();
    @(negedge clk) begin
      check("frz_fwd_b", 32'(fwd_sel_b), 2);
      check("frz_stall_cnt", 32'(stall_cnt), 1);
    end

    // Counter saturation: self-dependent load stalls every other cycle.
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 6, 1, 1, 6, 1, 0, 0, 0, 0);
    nop();
    @(negedge clk) check("sat_stall_cnt", 32'(stall_cnt), CNT_MAX);

    // Async reset in the middle of a stall silences outputs immediately.
    step(1, 6, 1, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive_in(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
    #1 check("mid_stall_before", 32'(stall_if_id), 1);
    #1 begin
      reset = 1'b1;
      branch_taken = 1'b1;
    end
    #1 begin
      check("rst_stall",  32'(stall_if_id),  0);
      check("rst_bubble", 32'(bubble_id_ex), 0);
      check("rst_flush",  32'(flush),        0);
      check("rst_fwd_b",  32'(fwd_sel_b),    0);
      check("rst_cnt",    32'(stall_cnt),    0);
    end
    model_reset();
    @(negedge clk); #1;
    drive_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);

    for (int i = 0; i < 5 && want_q.size() > 0; i++) @(negedge clk);
    check("drain", want_q.size(), 0);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
